// File: rtl/slave_pkg.sv
// Shared constants, state encoding and sizing helper for the SPI slave.
package slave_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Bit counter must hold 0..WIDTH-1 with one bit of headroom.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load, serial-in/serial-out shift register, MSB shifts out first.
module spi_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Load takes priority over shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift_en) begin
            q <= {q[WIDTH-2:0], sin};
        end
    end

endmodule

// File: rtl/slave.sv
// SPI mode-0 slave: frame FSM, one-deep transmit buffer and receive strobe.
module slave
    import slave_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             sclk,
    input  logic             reset,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] SDS,
    input  logic             SDS_load,
    output logic             SDS_ready,
    output logic [WIDTH-1:0] SDO,
    output logic             SDO_valid,
    output logic             underrun
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, cnt_nxt;
    logic             full, full_nxt;
    logic [WIDTH-1:0] tx_hold;
    logic [WIDTH-1:0] tx_q, rx_q;
    logic [WIDTH-1:0] tx_load_data;
    logic             cs_act, frame_start, last_bit, tx_shift_en, load_ok;
    logic             unused_bits;

    assign cs_act      = ~CS;
    assign frame_start = (state == IDLE) && cs_act;
    assign last_bit    = (state == SHIFT) && cs_act && (bit_cnt == CNT_W'(WIDTH - 1));
    assign tx_shift_en = (state == SHIFT) && cs_act;
    // A starting frame empties the buffer on the same edge, so a load there is accepted.
    assign load_ok     = SDS_load && (!full || frame_start);
    // MSB is presented from the buffer before the first edge, so the frame starts one bit in.
    assign tx_load_data = full ? {tx_hold[WIDTH-2:0], 1'b0} : '0;

    assign SDS_ready   = ~full;
    assign MISO        = (state == SHIFT) ? tx_q[WIDTH-1] : (full & tx_hold[WIDTH-1]);
    assign unused_bits = ^{tx_q[WIDTH-2:0], rx_q[WIDTH-1]};

    // Next-state, bit counter and buffer-occupancy logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        full_nxt  = full;
        case (state)
            IDLE: begin
                if (cs_act) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            SHIFT: begin
                if (!cs_act || last_bit) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (frame_start) begin
            full_nxt = 1'b0;
        end
        if (load_ok) begin
            full_nxt = 1'b1;
        end
    end

    // FSM, counter and buffer state registers.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            full    <= 1'b0;
            tx_hold <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= cnt_nxt;
            full    <= full_nxt;
            if (load_ok) begin
                tx_hold <= SDS;
            end
        end
    end

    // Received word, receive strobe and sticky underrun flag.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            SDO       <= '0;
            SDO_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            SDO_valid <= last_bit;
            if (last_bit) begin
                SDO <= {rx_q[WIDTH-2:0], MOSI};
            end
            if (frame_start && !full) begin
                underrun <= 1'b1;
            end
        end
    end

    spi_shift_reg #(.WIDTH(WIDTH)) u_tx (
        .clk      (sclk),
        .rst_n    (reset),
        .load     (frame_start),
        .din      (tx_load_data),
        .shift_en (tx_shift_en),
        .sin      (1'b0),
        .q        (tx_q)
    );

    spi_shift_reg #(.WIDTH(WIDTH)) u_rx (
        .clk      (sclk),
        .rst_n    (reset),
        .load     (1'b0),
        .din      ('0),
        .shift_en (cs_act),
        .sin      (MOSI),
        .q        (rx_q)
    );

endmodule

// File: tb/tb_slave.sv
// Bench for the SPI slave: directed frames plus random traffic against a frame-level model.
module tb_slave;

    localparam int unsigned W = 8;

    logic         sclk = 1'b0;
    logic         reset = 1'b0;
    logic         CS = 1'b1;
    logic         MOSI = 1'b0;
    logic         MISO;
    logic [W-1:0] SDS = '0;
    logic         SDS_load = 1'b0;
    logic         SDS_ready;
    logic [W-1:0] SDO;
    logic         SDO_valid;
    logic         underrun;

    int n_checks = 0;
    int n_pass   = 0;

    // Frame-level model: buffer contents, word in flight, bit position within frame.
    bit           m_full;
    logic [W-1:0] m_hold, m_word, m_rx, m_sdo;
    bit           m_valid, m_under;
    int           m_pos;

    slave #(.WIDTH(W)) dut (
        .sclk      (sclk),
        .reset     (reset),
        .CS        (CS),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .SDS       (SDS),
        .SDS_load  (SDS_load),
        .SDS_ready (SDS_ready),
        .SDO       (SDO),
        .SDO_valid (SDO_valid),
        .underrun  (underrun)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_full = 0; m_hold = '0; m_word = '0; m_rx = '0; m_sdo = '0;
        m_valid = 0; m_under = 0; m_pos = 0;
    endtask

    function automatic logic exp_miso();
        if (m_pos == 0) return m_full ? m_hold[W-1] : 1'b0;
        return m_word[W-1-m_pos];
    endfunction

    // One rising edge of the protocol, applied to the model.
    task automatic model_edge(input logic cs, input logic mosi, input logic load, input logic [W-1:0] sds);
        bit start, was_full;
        start    = (cs == 1'b0) && (m_pos == 0);
        was_full = m_full;
        m_valid  = 0;
        if (start) begin
            if (m_full) m_word = m_hold;
            else begin m_word = '0; m_under = 1; end
            m_full = 0;
            m_rx   = {m_rx[W-2:0], mosi};
            m_pos  = 1;
        end else if (cs == 1'b0) begin
            m_rx  = {m_rx[W-2:0], mosi};
            m_pos = m_pos + 1;
            if (m_pos == W) begin
                m_sdo   = m_rx;
                m_valid = 1;
                m_pos   = 0;
            end
        end else begin
            m_pos = 0;
        end
        if (load && (!was_full || start)) begin
            m_hold = sds;
            m_full = 1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".miso"},  32'(MISO),      32'(exp_miso()));
        check({tag, ".ready"}, 32'(SDS_ready), 32'(!m_full));
        check({tag, ".sdo"},   32'(SDO),       32'(m_sdo));
        check({tag, ".valid"}, 32'(SDO_valid), 32'(m_valid));
        check({tag, ".under"}, 32'(underrun),  32'(m_under));
    endtask

    // Called at a falling edge: drive, check, take the rising edge, return at the next falling edge.
    task automatic step(input string tag, input logic cs, input logic mosi, input logic load,
                        input logic [W-1:0] sds, output logic miso_o);
        CS = cs; MOSI = mosi; SDS_load = load; SDS = sds;
        #1;
        check_outputs(tag);
        miso_o = MISO;
        @(posedge sclk);
        model_edge(cs, mosi, load, sds);
        @(negedge sclk);
    endtask

    task automatic frame(input string tag, input logic [W-1:0] mo, input int load_at,
                         input logic [W-1:0] ld, output logic [W-1:0] mb);
        logic b;
        mb = '0;
        for (int i = 0; i < W; i++) begin
            step(tag, 1'b0, mo[W-1-i], (i == load_at), ld, b);
            mb = {mb[W-2:0], b};
        end
    endtask

    initial begin
        logic         b;
        logic [W-1:0] mb, mb1, mb2, pat;

        model_reset();
        repeat (10) @(negedge sclk);
        check_outputs("reset");
        reset = 1'b1;
        step("idle", 1'b1, 1'b0, 1'b0, '0, b);

        // Single frame with a loaded buffer.
        step("ld_a5", 1'b1, 1'b0, 1'b1, 8'hA5, b);
        frame("f3c", 8'h3C, -1, '0, mb);
        check("t1_miso_byte", 32'(mb), 32'h A5);
        check("t1_sdo", 32'(SDO), 32'h3C);
        check("t1_valid", 32'(SDO_valid), 32'd1);
        step("t1_after", 1'b1, 1'b0, 1'b0, '0, b);

        // Back-to-back frames with a mid-frame reload.
        step("ld_81", 1'b1, 1'b0, 1'b1, 8'h81, b);
        frame("fff", 8'hFF, 3, 8'h7E, mb1);
        check("t2_sdo1", 32'(SDO), 32'hFF);
        check("t2_valid1", 32'(SDO_valid), 32'd1);
        frame("f00", 8'h00, -1, '0, mb2);
        check("t2_miso1", 32'(mb1), 32'h81);
        check("t2_miso2", 32'(mb2), 32'h7E);
        check("t2_sdo2", 32'(SDO), 32'h00);
        check("t2_valid2", 32'(SDO_valid), 32'd1);
        step("t2_after", 1'b1, 1'b0, 1'b0, '0, b);

        // Underrun: frame with empty buffer.
        frame("f55", 8'h55, -1, '0, mb);
        check("t3_miso", 32'(mb), 32'h00);
        check("t3_sdo", 32'(SDO), 32'h55);
        step("t3_a", 1'b1, 1'b0, 1'b0, '0, b);
        step("t3_b", 1'b1, 1'b0, 1'b0, '0, b);
        check("t3_under_sticky", 32'(underrun), 32'd1);

        // Abort after four bits, then a full frame.
        pat = 8'hF0;
        for (int i = 0; i < 4; i++) step("abort", 1'b0, pat[W-1-i], 1'b0, '0, b);
        step("abort_cs", 1'b1, 1'b0, 1'b0, '0, b);
        check("t4_sdo_kept", 32'(SDO), 32'h55);
        step("abort_idle", 1'b1, 1'b0, 1'b0, '0, b);
        frame("f12", 8'h12, -1, '0, mb);
        check("t4_sdo", 32'(SDO), 32'h12);
        step("t4_after", 1'b1, 1'b0, 1'b0, '0, b);

        // Reset in the middle of a frame.
        step("ld_99", 1'b1, 1'b0, 1'b1, 8'h99, b);
        pat = 8'hC3;
        for (int i = 0; i < 4; i++) step("pre_rst", 1'b0, pat[W-1-i], 1'b0, '0, b);
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_rst");
        CS = 1'b1;
        repeat (3) @(negedge sclk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step("post_rst", 1'b1, 1'b1, 1'b0, '0, b);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 9) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
                 W'($urandom), b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/slave.md
# slave

SPI slave (mode 0, MSB first): the far end of the `master` link. It receives frames from the master on MOSI and returns a byte per frame on MISO. It sits on the device side of the link. It exposes a byte-level receive strobe and a one-deep transmit buffer with a ready/load handshake to local logic. Everything is clocked by the shared serial clock `sclk`.

## Interface
- `WIDTH`, 8: frame length in bits; also the width of `SDS` and `SDO`.
- `sclk`  in  1  serial clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `CS`  in  1  chip select, active-low; frames occur only while low.
- `MOSI`  in  1  serial data from master, sampled on rising `sclk`.
- `MISO`  out  1  serial data to master, MSB of the current transmit word.
- `SDS`  in  WIDTH  slave data to send; captured when `SDS_load`=1 and `SDS_ready`=1.
- `SDS_load`  in  1  load strobe for `SDS`.
- `SDS_ready`  out  1  1 when the transmit buffer is empty.
- `SDO`  out  WIDTH  last completely received frame.
- `SDO_valid`  out  1  one-cycle pulse when `SDO` updates.
- `underrun`  out  1  sticky; a frame started with an empty transmit buffer.

## Operation
- Registers:
  - `tx_hold` (buffer) with a full flag.
  - `tx_shift` and `rx_shift`, each WIDTH wide.
  - `bit_cnt`, $clog2(WIDTH)+1 bits wide.
  - `state`: IDLE or SHIFT.
- MISO is driven combinationally from registers only:
  - IDLE: `tx_hold[WIDTH-1]` if the buffer is full, else 0.
  - SHIFT: `tx_shift[WIDTH-1]`.
- IDLE, rising edge with CS=0 (start of frame):
  - `tx_shift` <= `{tx_hold[WIDTH-2:0],0}`, so the MSB has already been presented.
  - `rx_shift` <= `{..., MOSI}`; `bit_cnt` <= 1; go to SHIFT.
  - Buffer becomes empty.
  - If the buffer was empty: transmit all zeros and set `underrun`.
- SHIFT, rising edge with CS=0 and `bit_cnt` < WIDTH-1:
  - Shift MOSI into `rx_shift` LSB and shift `tx_shift` left.
  - `bit_cnt` increments.
- SHIFT, rising edge with CS=0 and `bit_cnt` = WIDTH-1 (last bit):
  - `SDO` <= `{rx_shift[WIDTH-2:0], MOSI}`; `SDO_valid` <= 1 for one cycle.
  - `bit_cnt` <= 0; state returns to IDLE.
  - Because CS is still low, the next edge starts a new frame back to back with no gap.
- SHIFT, rising edge with CS=1 (abort):
  - Partial frame is discarded; no `SDO_valid`; return to IDLE.
  - The transmit word already consumed is not resent.
- CS=1 in IDLE: nothing shifts and MISO holds its value.
- Transmit handshake:
  - `SDS_ready` = !full.
  - A load with ready=1 sets full on that edge.
  - A load with ready=0 is ignored and the held data is unchanged.
  - Load on the same edge a frame starts: the frame consumes the old contents (or underruns when empty). The new `SDS` is stored and full stays 1.
- `underrun` clears only on reset.

## Timing
- Reset (async assert, released synchronously to the design by the environment) forces:
  - MISO=0, SDO=0, SDO_valid=0, SDS_ready=1, underrun=0.
  - state=IDLE, bit_cnt=0, buffer empty, shift registers 0.
- Receive latency: `SDO`/`SDO_valid` are registered at the edge that samples the last bit, so they are visible for the following cycle.
- Frame = exactly WIDTH rising edges with CS low. For WIDTH=8, frame k+1 begins on edge 8k+1 when CS stays low.
- A reset during SHIFT aborts immediately; no strobe is issued.

## Structure
- Package `slave_pkg`:
  - state encoding (IDLE=1'b0, SHIFT=1'b1);
  - default `WIDTH`;
  - the bit-counter width function.
- One sub-module: `spi_shift_reg` (parallel load, serial in/out, WIDTH parameter), instantiated twice (tx, rx). The FSM, buffer and handshake stay in `slave`.

## Test plan
- Reset held low 10 cycles → all outputs at reset values; release → SDS_ready=1, MISO=0.
- Load SDS=0xA5 and then hold CS low 8 edges while master sends 0x3C:
  - MISO bits over the frame are 1,0,1,0,0,1,0,1.
  - SDO=0x3C with a single SDO_valid pulse after edge 8.
  - SDS_ready returns 1 at frame start.
- Back-to-back frames: load 0x81, start frame, load 0x7E mid-frame, CS low for 16 edges with master sending 0xFF then 0x00:
  - MISO returns 0x81 then 0x7E.
  - SDO_valid pulses after edges 8 and 16 with SDO 0xFF then 0x00.
- Underrun: start a frame with the buffer empty, master sends 0x55 → MISO all 0, SDO=0x55, underrun=1 and it stays 1.
- Abort: CS high after 4 edges of 0xF0 → no SDO_valid, SDO unchanged; next full frame 0x12 → SDO=0x12.
- Reset asserted at edge 5 of a frame → outputs at reset values immediately; no SDO_valid afterwards.
